// File: rtl/sl_apb_pkg.sv
// Shared definitions for the serial-line APB bridge: register map, the
// bridge state type and the command record captured at accept time.
package sl_apb_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Responder register map
    localparam logic [ADDR_WIDTH-1:0] DATA_REG_ADDR   = 10'd5;
    localparam logic [ADDR_WIDTH-1:0] CONFIG_REG_ADDR = 10'd6;
    localparam logic [ADDR_WIDTH-1:0] STATUS_REG_ADDR = 10'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
    } apb_cmd_t;

    // Reads never drive write data or strobes onto the bus.
    function automatic apb_cmd_t mask_read(input apb_cmd_t c);
        apb_cmd_t m;
        m = c;
        if (!c.write) begin
            m.wdata = '0;
            m.strb  = '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts responder wait cycles and flags the wait
// cycle that brings the count to TIMEOUT_CYCLES. A ready on that same cycle
// is not a wait cycle, so a late-but-in-time responder still completes.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_wait,
    output logic o_expired
);

    localparam int CLOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wait-cycle counter, restarted before every ACCESS phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_wait) r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_expired = i_wait && (r_cnt == LAST_WAIT);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: single outstanding command in, SETUP/ACCESS transfer on
// APB, single response out. Optional ACCESS watchdog when
// APB_MASTER_TIMEOUT_EN is defined; otherwise ACCESS waits indefinitely.
// The command register follows the sl_apb_pkg widths, so ADDR_WIDTH and
// DATA_WIDTH must stay equal to the package values.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    import sl_apb_pkg::*;

    apb_state_e            r_state, w_state_nxt;
    apb_cmd_t              r_cmd, w_cmd_nxt;
    logic                  r_psel, w_psel_nxt;
    logic                  r_penable, w_penable_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_err, w_rsp_err_nxt;
    logic                  w_cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic                  r_rsp_timeout, w_rsp_timeout_nxt;
    logic                  w_expired;
`endif

    assign w_cmd_ready = (r_state == IDLE) && !preset;

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
        w_rsp_timeout_nxt = r_rsp_timeout;
`endif
        case (r_state)
            IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_cmd_nxt   = mask_read('{addr:  cmd_addr,
                                              write: cmd_write,
                                              wdata: cmd_wdata,
                                              strb:  cmd_strb});
                    w_psel_nxt  = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    w_rsp_rdata_nxt = r_cmd.write ? '0 : prdata;
                    w_rsp_err_nxt   = pslverr;
`ifdef APB_MASTER_TIMEOUT_EN
                    w_rsp_timeout_nxt = 1'b0;
`endif
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (w_expired) begin
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Registered APB and response outputs; reset kills any in-flight transfer
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_cmd       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cmd       <= w_cmd_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout flag register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) r_rsp_timeout <= 1'b0;
        else        r_rsp_timeout <= w_rsp_timeout_nxt;
    end

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (pclk),
        .i_rst     (preset),
        .i_clr     (r_state == SETUP),
        .i_wait    ((r_state == ACCESS) && !pready),
        .o_expired (w_expired)
    );

    assign rsp_timeout = r_rsp_timeout;
`else
    logic [31:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = TIMEOUT_CYCLES;
    assign rsp_timeout          = 1'b0;
`endif

    assign cmd_ready = w_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign paddr     = r_cmd.addr;
    assign pwrite    = r_cmd.write;
    assign pwdata    = r_cmd.wdata;
    assign pstrb     = r_cmd.strb;
    assign psel      = r_psel;
    assign penable   = r_penable;

    // An enable phase is always framed by select
    a_penable_psel: assert property (@(posedge pclk) disable iff (preset) penable |-> psel);

endmodule
